// File: rtl/ej32_rs_arb.sv
// Return-stack arbiter and sequencer for the eJ32 core: port A (branch) has priority,
// port B (debug/trap) can lock the stack and is protected from starvation.
// Define EJ32_RS_GUARD_EN to enable depth tracking, overflow/underflow guarding and sticky err.
module ej32_rs_arb #(
  parameter int DSZ    = 32,
  parameter int SSZ    = 6,
  parameter int STARVE = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           a_req,
  input  logic [2:0]     a_op,
  input  logic [SSZ-1:0] a_off,
  input  logic [DSZ-1:0] a_wd,
  output logic           a_gnt,
  output logic           a_rv,
  output logic [DSZ-1:0] a_rd,
  input  logic           b_req,
  input  logic [2:0]     b_op,
  input  logic [SSZ-1:0] b_off,
  input  logic [DSZ-1:0] b_wd,
  output logic           b_gnt,
  output logic           b_rv,
  output logic [DSZ-1:0] b_rd,
  input  logic           b_lock,
  output logic           a_stall,
  output logic           rs_ren,
  output logic           rs_wen,
  output logic [SSZ-1:0] rs_raddr,
  output logic [SSZ-1:0] rs_waddr,
  output logic [DSZ-1:0] rs_wdata,
  input  logic [DSZ-1:0] rs_rdata,
  output logic [SSZ-1:0] rp,
  output logic [1:0]     err,
  input  logic           err_clr
);

  localparam int CW = $clog2(STARVE + 1);
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_MOVE = 3'd3;
  localparam logic [2:0] OP_READ = 3'd4;
  localparam logic [2:0] OP_POPR = 3'd5;

  typedef enum logic {ARB, LOCK} state_t;

  state_t         state;
  logic [CW-1:0]  starve_cnt;
  logic           arb_mode;
  logic           force_b;
  logic           xfer;
  logic [2:0]     op;
  logic [SSZ-1:0] off;
  logic [DSZ-1:0] wd;
  logic           full;
  logic           empty;
  logic           push_ok;
  logic           pop_ok;
  logic           rd_issue;
  logic           rd_zero;
  logic           ovf;
  logic           unf;
  logic           hit;
  logic [SSZ-1:0] rp_nxt;
  logic           last_wen;
  logic [SSZ-1:0] last_waddr;
  logic [DSZ-1:0] last_wdata;
  logic           a_pend;
  logic           b_pend;
  logic           byp;
  logic           zero_q;
  logic [DSZ-1:0] byp_data;
  logic [DSZ-1:0] a_hold;
  logic [DSZ-1:0] b_hold;
  logic [DSZ-1:0] ret_data;

  // Dropping b_lock releases the lock in the same cycle, so normal arbitration applies then.
  assign arb_mode = (state == ARB) || !b_lock;
  assign force_b  = arb_mode && a_req && b_req && (starve_cnt == CW'(STARVE));

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!arb_mode)
      b_gnt = b_req;
    else if (force_b)
      b_gnt = 1'b1;
    else if (a_req)
      a_gnt = 1'b1;
    else
      b_gnt = b_req;
  end

  assign a_stall = a_req && !a_gnt;
  assign xfer    = a_gnt || b_gnt;
  assign op      = a_gnt ? a_op  : b_op;
  assign off     = a_gnt ? a_off : b_off;
  assign wd      = a_gnt ? a_wd  : b_wd;

  always_comb begin
    rs_ren   = 1'b0;
    rs_wen   = 1'b0;
    rs_raddr = '0;
    rs_waddr = '0;
    rs_wdata = '0;
    push_ok  = 1'b0;
    pop_ok   = 1'b0;
    rd_issue = 1'b0;
    rd_zero  = 1'b0;
    ovf      = 1'b0;
    unf      = 1'b0;
    if (xfer) begin
      case (op)
        OP_PUSH: begin
          if (full) begin
            ovf = 1'b1;
          end else begin
            rs_wen   = 1'b1;
            rs_waddr = rp + SSZ'(1);
            rs_wdata = wd;
            push_ok  = 1'b1;
          end
        end
        OP_POP: begin
          if (empty) unf = 1'b1;
          else       pop_ok = 1'b1;
        end
        OP_MOVE: begin
          rs_wen   = 1'b1;
          rs_waddr = rp;
          rs_wdata = wd;
        end
        OP_READ: begin
          rs_ren   = 1'b1;
          rs_raddr = rp - off;
          rd_issue = 1'b1;
        end
        OP_POPR: begin
          rd_issue = 1'b1;
          // An underflowing POPR still answers, with zero instead of stack data.
          if (empty) begin
            unf     = 1'b1;
            rd_zero = 1'b1;
          end else begin
            rs_ren   = 1'b1;
            rs_raddr = rp;
            pop_ok   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rp_nxt = push_ok ? rp + SSZ'(1) : (pop_ok ? rp - SSZ'(1) : rp);

  // The BRAM does not yet hold last cycle's write when we read it, so forward it.
  assign hit      = rs_ren && last_wen && (rs_raddr == last_waddr);
  assign ret_data = zero_q ? '0 : (byp ? byp_data : rs_rdata);
  assign a_rv     = a_pend;
  assign b_rv     = b_pend;
  assign a_rd     = a_pend ? ret_data : a_hold;
  assign b_rd     = b_pend ? ret_data : b_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      starve_cnt <= '0;
    end else begin
      if (b_gnt)
        starve_cnt <= '0;
      else if (a_gnt && b_req)
        starve_cnt <= starve_cnt + CW'(1);
      case (state)
        ARB:     if (b_gnt && b_lock) state <= LOCK;
        LOCK:    if (!b_lock) state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rp         <= '0;
      last_wen   <= 1'b0;
      last_waddr <= '0;
      last_wdata <= '0;
      a_pend     <= 1'b0;
      b_pend     <= 1'b0;
      byp        <= 1'b0;
      byp_data   <= '0;
      zero_q     <= 1'b0;
      a_hold     <= '0;
      b_hold     <= '0;
    end else begin
      rp         <= rp_nxt;
      last_wen   <= rs_wen;
      last_waddr <= rs_waddr;
      last_wdata <= rs_wdata;
      a_pend     <= a_gnt && rd_issue;
      b_pend     <= b_gnt && rd_issue;
      byp        <= hit;
      byp_data   <= last_wdata;
      zero_q     <= rd_zero;
      if (a_pend) a_hold <= ret_data;
      if (b_pend) b_hold <= ret_data;
    end
  end

`ifdef EJ32_RS_GUARD_EN
  logic [SSZ:0] depth;

  assign full  = (depth == (SSZ+1)'(2**SSZ));
  assign empty = (depth == '0);

  // A new error in the same cycle as err_clr is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
      err   <= '0;
    end else begin
      if (push_ok)
        depth <= depth + (SSZ+1)'(1);
      else if (pop_ok)
        depth <= depth - (SSZ+1)'(1);
      err <= (err & {2{~err_clr}}) | {unf, ovf};
    end
  end
`else
  logic unused_ok;

  assign full      = 1'b0;
  assign empty     = 1'b0;
  assign err       = '0;
  assign unused_ok = &{1'b0, err_clr, ovf, unf};
`endif

endmodule

// File: tb/tb_ej32_rs_arb.sv
// Self-checking bench for ej32_rs_arb: vector table for arbitration/data paths plus
// hand-written reset, wrap and guard sequences against a BRAM model with delayed write commit.
module tb_ej32_rs_arb;

  localparam int DSZ = 32;
  localparam int SSZ = 6;
  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] PUSH = 3'd1;
  localparam logic [2:0] POP  = 3'd2;
  localparam logic [2:0] MOVE = 3'd3;
  localparam logic [2:0] READ = 3'd4;
  localparam logic [2:0] POPR = 3'd5;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
`ifdef EJ32_RS_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int NPOP = GUARD ? 64 : 65;

  logic           clk;
  logic           rst;
  logic           a_req, b_req, b_lock, err_clr;
  logic [2:0]     a_op, b_op;
  logic [SSZ-1:0] a_off, b_off;
  logic [DSZ-1:0] a_wd, b_wd;
  logic           a_gnt, a_rv, b_gnt, b_rv, a_stall;
  logic [DSZ-1:0] a_rd, b_rd;
  logic           rs_ren, rs_wen;
  logic [SSZ-1:0] rs_raddr, rs_waddr, rp;
  logic [DSZ-1:0] rs_wdata, rs_rdata;
  logic [1:0]     err;

  int checks;
  int errors;

  typedef struct {
    logic           a_req;
    logic [2:0]     a_op;
    logic [SSZ-1:0] a_off;
    logic [DSZ-1:0] a_wd;
    logic           b_req;
    logic [2:0]     b_op;
    logic [SSZ-1:0] b_off;
    logic [DSZ-1:0] b_wd;
    logic           b_lock;
    logic           e_a_gnt;
    logic           e_b_gnt;
    logic           e_stall;
    logic [SSZ-1:0] e_rp;
    logic           e_a_rv;
    logic [DSZ-1:0] e_a_rd;
    logic           e_b_rv;
    logic [DSZ-1:0] e_b_rd;
  } vec_t;

  vec_t vecs[$];

  ej32_rs_arb #(.DSZ(DSZ), .SSZ(SSZ), .STARVE(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_op(a_op), .a_off(a_off), .a_wd(a_wd),
    .a_gnt(a_gnt), .a_rv(a_rv), .a_rd(a_rd),
    .b_req(b_req), .b_op(b_op), .b_off(b_off), .b_wd(b_wd),
    .b_gnt(b_gnt), .b_rv(b_rv), .b_rd(b_rd),
    .b_lock(b_lock), .a_stall(a_stall),
    .rs_ren(rs_ren), .rs_wen(rs_wen), .rs_raddr(rs_raddr), .rs_waddr(rs_waddr),
    .rs_wdata(rs_wdata), .rs_rdata(rs_rdata),
    .rp(rp), .err(err), .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM model whose writes land one cycle late, so reading a just-written word returns stale data.
  logic [DSZ-1:0] mem [0:63];
  logic           wq_v;
  logic [SSZ-1:0] wq_a;
  logic [DSZ-1:0] wq_d;

  always @(posedge clk) begin
    if (rs_ren) rs_rdata <= mem[rs_raddr];
    if (wq_v) mem[wq_a] <= wq_d;
    if (rst) wq_v <= 1'b0;
    else     wq_v <= rs_wen;
    wq_a <= rs_waddr;
    wq_d <= rs_wdata;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(
    input logic ar, input logic [2:0] ao, input logic [SSZ-1:0] aoff, input logic [DSZ-1:0] awd,
    input logic br, input logic [2:0] bo, input logic [SSZ-1:0] boff, input logic [DSZ-1:0] bwd,
    input logic bl, input logic eag, input logic ebg, input logic est, input logic [SSZ-1:0] erp,
    input logic earv, input logic [DSZ-1:0] eard, input logic ebrv, input logic [DSZ-1:0] ebrd);
    vec_t v;
    v.a_req = ar;  v.a_op = ao;  v.a_off = aoff;  v.a_wd = awd;
    v.b_req = br;  v.b_op = bo;  v.b_off = boff;  v.b_wd = bwd;  v.b_lock = bl;
    v.e_a_gnt = eag;  v.e_b_gnt = ebg;  v.e_stall = est;  v.e_rp = erp;
    v.e_a_rv = earv;  v.e_a_rd = eard;  v.e_b_rv = ebrv;  v.e_b_rd = ebrd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    a_req = v.a_req;  a_op = v.a_op;  a_off = v.a_off;  a_wd = v.a_wd;
    b_req = v.b_req;  b_op = v.b_op;  b_off = v.b_off;  b_wd = v.b_wd;
    b_lock = v.b_lock;
    err_clr = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    a_req = 1'b0; a_op = NOP; a_off = '0; a_wd = '0;
    b_req = 1'b0; b_op = NOP; b_off = '0; b_wd = '0;
    b_lock = 1'b0; err_clr = 1'b0;
  endtask

  task automatic runVec(input int idx, input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput($sformatf("v%0d a_gnt", idx), 32'(a_gnt), 32'(v.e_a_gnt));
    checkOutput($sformatf("v%0d b_gnt", idx), 32'(b_gnt), 32'(v.e_b_gnt));
    checkOutput($sformatf("v%0d a_stall", idx), 32'(a_stall), 32'(v.e_stall));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d rp", idx), 32'(rp), 32'(v.e_rp));
    checkOutput($sformatf("v%0d a_rv", idx), 32'(a_rv), 32'(v.e_a_rv));
    checkOutput($sformatf("v%0d a_rd", idx), a_rd, v.e_a_rd);
    checkOutput($sformatf("v%0d b_rv", idx), 32'(b_rv), 32'(v.e_b_rv));
    checkOutput($sformatf("v%0d b_rd", idx), b_rd, v.e_b_rd);
  endtask

  task automatic aOp(input logic [2:0] op, input logic [DSZ-1:0] wd, input logic clr);
    @(negedge clk);
    a_req = 1'b1; a_op = op; a_off = '0; a_wd = wd;
    b_req = 1'b0; b_op = NOP; b_lock = 1'b0; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a_req = 1'b0; a_op = NOP; a_off = '0; a_wd = '0;
    b_req = 1'b0; b_op = NOP; b_off = '0; b_wd = '0;
    b_lock = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset rp", 32'(rp), 32'd0);
    checkOutput("reset a_rv", 32'(a_rv), 32'd0);
    checkOutput("reset b_rv", 32'(b_rv), 32'd0);
    checkOutput("reset a_rd", a_rd, 32'd0);
    checkOutput("reset b_rd", b_rd, 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset a_stall", 32'(a_stall), 32'd0);
    checkOutput("reset gnt", 32'({a_gnt, b_gnt}), 32'd0);
    checkOutput("reset bram en", 32'({rs_ren, rs_wen}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // push three, pop them back with POPR (first one comes through the bypass)
    vecs.push_back(mk(Y, PUSH, 6'd0, 32'h11, N, NOP, 6'd0, 32'h0, N, Y, N, N, 6'd1, N, 32'h0,  N, 32'h0));
    vecs.push_back(mk(Y, PUSH, 6'd0, 32'h22, N, NOP, 6'd0, 32'h0, N, Y, N, N, 6'd2, N, 32'h0,  N, 32'h0));
    vecs.push_back(mk(Y, PUSH, 6'd0, 32'h33, N, NOP, 6'd0, 32'h0, N, Y, N, N, 6'd3, N, 32'h0,  N, 32'h0));
    vecs.push_back(mk(Y, POPR, 6'd0, 32'h0,  N, NOP, 6'd0, 32'h0, N, Y, N, N, 6'd2, Y, 32'h33, N, 32'h0));
    vecs.push_back(mk(Y, POPR, 6'd0, 32'h0,  N, NOP, 6'd0, 32'h0, N, Y, N, N, 6'd1, Y, 32'h22, N, 32'h0));
    vecs.push_back(mk(Y, POPR, 6'd0, 32'h0,  N, NOP, 6'd0, 32'h0, N, Y, N, N, 6'd0, Y, 32'h11, N, 32'h0));
    vecs.push_back(mk(N, NOP,  6'd0, 32'h0,  N, NOP, 6'd0, 32'h0, N, N, N, N, 6'd0, N, 32'h11, N, 32'h0));
    // collision, then read both words back from each port
    vecs.push_back(mk(Y, PUSH, 6'd0, 32'h44, Y, PUSH, 6'd0, 32'h55, N, Y, N, N, 6'd1, N, 32'h11, N, 32'h0));
    vecs.push_back(mk(N, NOP,  6'd0, 32'h0,  Y, PUSH, 6'd0, 32'h55, N, N, Y, N, 6'd2, N, 32'h11, N, 32'h0));
    vecs.push_back(mk(Y, READ, 6'd0, 32'h0,  N, NOP,  6'd0, 32'h0,  N, Y, N, N, 6'd2, Y, 32'h55, N, 32'h0));
    vecs.push_back(mk(N, NOP,  6'd0, 32'h0,  Y, READ, 6'd1, 32'h0,  N, N, Y, N, 6'd2, N, 32'h55, Y, 32'h44));
    // starvation: four A wins then a forced B grant, twice
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++)
        vecs.push_back(mk(Y, NOP, 6'd0, 32'h0, Y, NOP, 6'd0, 32'h0, N, Y, N, N, 6'd2, N, 32'h55, N, 32'h44));
      vecs.push_back(mk(Y, NOP, 6'd0, 32'h0, Y, NOP, 6'd0, 32'h0, N, N, Y, Y, 6'd2, N, 32'h55, N, 32'h44));
    end
    // lock: B takes the lock, holds it three cycles against A, then releases
    vecs.push_back(mk(N, NOP,  6'd0, 32'h0,  Y, PUSH, 6'd0, 32'h70, Y, N, Y, N, 6'd3, N, 32'h55, N, 32'h44));
    vecs.push_back(mk(Y, PUSH, 6'd0, 32'h66, Y, PUSH, 6'd0, 32'h71, Y, N, Y, Y, 6'd4, N, 32'h55, N, 32'h44));
    vecs.push_back(mk(Y, PUSH, 6'd0, 32'h66, Y, PUSH, 6'd0, 32'h72, Y, N, Y, Y, 6'd5, N, 32'h55, N, 32'h44));
    vecs.push_back(mk(Y, PUSH, 6'd0, 32'h66, Y, PUSH, 6'd0, 32'h73, Y, N, Y, Y, 6'd6, N, 32'h55, N, 32'h44));
    vecs.push_back(mk(Y, PUSH, 6'd0, 32'h66, Y, PUSH, 6'd0, 32'h74, N, Y, N, N, 6'd7, N, 32'h55, N, 32'h44));
    // bypass: MOVE at rp=5 then immediate READ must not see the stale 0x72
    vecs.push_back(mk(Y, POP,  6'd0, 32'h0,    N, NOP, 6'd0, 32'h0, N, Y, N, N, 6'd6, N, 32'h55,   N, 32'h44));
    vecs.push_back(mk(Y, POP,  6'd0, 32'h0,    N, NOP, 6'd0, 32'h0, N, Y, N, N, 6'd5, N, 32'h55,   N, 32'h44));
    vecs.push_back(mk(Y, MOVE, 6'd0, 32'hDEAD, N, NOP, 6'd0, 32'h0, N, Y, N, N, 6'd5, N, 32'h55,   N, 32'h44));
    vecs.push_back(mk(Y, READ, 6'd0, 32'h0,    N, NOP, 6'd0, 32'h0, N, Y, N, N, 6'd5, Y, 32'hDEAD, N, 32'h44));
    vecs.push_back(mk(Y, READ, 6'd2, 32'h0,    N, NOP, 6'd0, 32'h0, N, Y, N, N, 6'd5, Y, 32'h70,   N, 32'h44));
    vecs.push_back(mk(Y, READ, 6'd0, 32'h0,    N, NOP, 6'd0, 32'h0, N, Y, N, N, 6'd5, Y, 32'hDEAD, N, 32'h44));
    vecs.push_back(mk(N, NOP,  6'd0, 32'h0,    N, NOP, 6'd0, 32'h0, N, N, N, N, 6'd5, N, 32'hDEAD, N, 32'h44));

    foreach (vecs[i]) runVec(i, vecs[i]);

    // reset on the cycle a READ is issued cancels its rv
    @(negedge clk);
    a_req = 1'b1; a_op = READ; a_off = '0; rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midread a_rv", 32'(a_rv), 32'd0);
    checkOutput("midread a_rd", a_rd, 32'd0);
    checkOutput("midread rp", 32'(rp), 32'd0);
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midread a_rv after", 32'(a_rv), 32'd0);

    // fill the whole stack, then one more push
    for (int i = 1; i <= 64; i++) aOp(PUSH, 32'(i), 1'b0);
    checkOutput("full rp", 32'(rp), 32'd0);
    checkOutput("full err", 32'(err), 32'd0);
    aOp(PUSH, 32'h99, 1'b0);
    checkOutput("overflow rp", 32'(rp), GUARD ? 32'd0 : 32'd1);
    checkOutput("overflow err", 32'(err), GUARD ? 32'd1 : 32'd0);
    aOp(NOP, 32'h0, 1'b1);
    checkOutput("clear err", 32'(err), 32'd0);

    for (int i = 0; i < NPOP; i++) aOp(POP, 32'h0, 1'b0);
    checkOutput("empty rp", 32'(rp), 32'd0);
    checkOutput("empty err", 32'(err), 32'd0);
    aOp(POP, 32'h0, 1'b0);
    checkOutput("underflow rp", 32'(rp), GUARD ? 32'd0 : 32'd63);
    checkOutput("underflow err", 32'(err), GUARD ? 32'd2 : 32'd0);
    aOp(POPR, 32'h0, 1'b1);
    checkOutput("popr err", 32'(err), GUARD ? 32'd2 : 32'd0);
    checkOutput("popr rp", 32'(rp), GUARD ? 32'd0 : 32'd62);
    checkOutput("popr a_rv", 32'(a_rv), 32'd1);
    checkOutput("popr a_rd", a_rd, GUARD ? 32'd0 : 32'd63);
    aOp(NOP, 32'h0, 1'b1);
    checkOutput("final clear err", 32'(err), 32'd0);
    checkOutput("final a_rv", 32'(a_rv), 32'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
